// File: rtl/req_gnt_delay_checker.sv
// Multi-channel request/grant latency checker: every request starts an attempt whose
// grant is checked a mode-selected number of cycles later; results are pulsed and counted.
module req_gnt_delay_checker #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MAX_DLY = 4,
    parameter int unsigned DLY_W   = $clog2(MAX_DLY + 1),
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [NUM_CH-1:0] req_i,
    input  logic [NUM_CH-1:0] gnt_i,
    input  logic [NUM_CH-1:0] check_i,
    input  logic [DLY_W-1:0]  dly_t_i,
    input  logic [DLY_W-1:0]  dly_f_i,
    output logic [NUM_CH-1:0] pass_o,
    output logic [NUM_CH-1:0] fail_o,
    output logic [CNT_W-1:0]  pass_cnt_o,
    output logic [CNT_W-1:0]  fail_cnt_o,
    output logic              err_o,
    output logic [CH_W-1:0]   err_ch_o
);

    localparam int unsigned SlotW = $clog2(MAX_DLY + 1);
    localparam int unsigned IdxW  = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
    localparam int unsigned SumW  = $clog2(NUM_CH * MAX_DLY + 1);
    localparam int unsigned AccW  = ((CNT_W > SumW) ? CNT_W : SumW) + 1;

    // slot_q[c][k] counts attempts on channel c that mature k+1 edges from now.
    logic [NUM_CH-1:0][MAX_DLY-1:0][SlotW-1:0] slot_q, slot_d;
    logic [NUM_CH-1:0] pass_q, pass_d, fail_q, fail_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic              err_q, err_d;
    logic [CH_W-1:0]   err_ch_q, err_ch_d;

    logic [SumW-1:0]   pass_sum, fail_sum;
    logic [AccW-1:0]   pass_acc, fail_acc;
    logic [DLY_W-1:0]  dly_sel;
    logic [31:0]       dly_cl;
    logic [IdxW-1:0]   dly_idx;

    always_comb begin
        slot_d   = '0;
        pass_d   = '0;
        fail_d   = '0;
        pass_sum = '0;
        fail_sum = '0;
        dly_sel  = '0;
        dly_cl   = 32'd1;
        dly_idx  = '0;

        for (int c = 0; c < int'(NUM_CH); c++) begin
            for (int k = 0; k < int'(MAX_DLY) - 1; k++) begin
                slot_d[c][k] = slot_q[c][k+1];
            end

            dly_sel = check_i[c] ? dly_t_i : dly_f_i;
            if (dly_sel == '0) begin
                dly_cl = 32'd1;
            end else if (32'(dly_sel) > MAX_DLY) begin
                dly_cl = MAX_DLY;
            end else begin
                dly_cl = 32'(dly_sel);
            end
            dly_idx = IdxW'(dly_cl - 32'd1);

            if (en_i && req_i[c]) begin
                slot_d[c][dly_idx] = slot_d[c][dly_idx] + SlotW'(1);
            end

            // All attempts maturing together share this edge's grant sample.
            if (slot_q[c][0] != '0) begin
                if (gnt_i[c]) begin
                    pass_d[c] = 1'b1;
                    pass_sum  = pass_sum + SumW'(slot_q[c][0]);
                end else begin
                    fail_d[c] = 1'b1;
                    fail_sum  = fail_sum + SumW'(slot_q[c][0]);
                end
            end
        end

        if (clr_i) begin
            slot_d   = '0;
            pass_d   = '0;
            fail_d   = '0;
            pass_sum = '0;
            fail_sum = '0;
        end
    end

    always_comb begin
        pass_acc   = AccW'(pass_cnt_q) + AccW'(pass_sum);
        fail_acc   = AccW'(fail_cnt_q) + AccW'(fail_sum);
        pass_cnt_d = (pass_acc[AccW-1:CNT_W] != '0) ? '1 : pass_acc[CNT_W-1:0];
        fail_cnt_d = (fail_acc[AccW-1:CNT_W] != '0) ? '1 : fail_acc[CNT_W-1:0];
        err_d      = err_q;
        err_ch_d   = err_ch_q;

        if (clr_i) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            err_d      = 1'b0;
            err_ch_d   = '0;
        end else if (!err_q && (fail_d != '0)) begin
            err_d = 1'b1;
            // Descending scan so the lowest failing channel is the one kept.
            for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
                if (fail_d[c]) begin
                    err_ch_d = CH_W'(c);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q     <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            err_q      <= 1'b0;
            err_ch_q   <= '0;
        end else begin
            slot_q     <= slot_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            err_q      <= err_d;
            err_ch_q   <= err_ch_d;
        end
    end

    assign pass_o     = pass_q;
    assign fail_o     = fail_q;
    assign pass_cnt_o = pass_cnt_q;
    assign fail_cnt_o = fail_cnt_q;
    assign err_o      = err_q;
    assign err_ch_o   = err_ch_q;

endmodule

// File: tb/tb_req_gnt_delay_checker.sv
// Directed bench for req_gnt_delay_checker: expected pulses are queued per edge as stimulus
// is applied and compared every cycle; counters and sticky error are checked at key points.
module tb_req_gnt_delay_checker;

    localparam int unsigned NumCh  = 4;
    localparam int unsigned MaxDly = 4;
    localparam int unsigned DlyW   = 3;
    localparam int unsigned CntW   = 4;

    logic            clk;
    logic            rst;
    logic            en;
    logic            clr;
    logic [3:0]      req;
    logic [3:0]      gnt;
    logic [3:0]      chk_m;
    logic [DlyW-1:0] dly_t;
    logic [DlyW-1:0] dly_f;
    logic [3:0]      pass;
    logic [3:0]      fail;
    logic [CntW-1:0] pass_cnt;
    logic [CntW-1:0] fail_cnt;
    logic            err;
    logic [1:0]      err_ch;

    typedef struct {
        int         at_cyc;
        logic [3:0] p;
        logic [3:0] f;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_chk;
    int   n_err;
    int   e;

    req_gnt_delay_checker #(
        .NUM_CH (NumCh),
        .MAX_DLY(MaxDly),
        .DLY_W  (DlyW),
        .CNT_W  (CntW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .clr_i     (clr),
        .req_i     (req),
        .gnt_i     (gnt),
        .check_i   (chk_m),
        .dly_t_i   (dly_t),
        .dly_f_i   (dly_f),
        .pass_o    (pass),
        .fail_o    (fail),
        .pass_cnt_o(pass_cnt),
        .fail_cnt_o(fail_cnt),
        .err_o     (err),
        .err_ch_o  (err_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic exp_at(input int at_cyc, input logic [3:0] p, input logic [3:0] f);
        exp_t x;
        x.at_cyc = at_cyc;
        x.p      = p;
        x.f      = f;
        sb.push_back(x);
    endtask

    // Advance one edge, then compare this edge's pulses against everything queued for it.
    task automatic tick();
        logic [3:0] ep;
        logic [3:0] ef;
        @(posedge clk);
        #2;
        cyc++;
        ep = '0;
        ef = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at_cyc == cyc) begin
                ep |= sb[i].p;
                ef |= sb[i].f;
                sb.delete(i);
            end
        end
        chk("pass_pulse", 32'(pass), 32'(ep));
        chk("fail_pulse", 32'(fail), 32'(ef));
    endtask

    task automatic clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        cyc   = 0;
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        en    = 1'b1;
        clr   = 1'b0;
        req   = '0;
        gnt   = '0;
        chk_m = '0;
        dly_t = '0;
        dly_f = '0;
        tick();
        tick();
        chk("rst_pass_cnt", 32'(pass_cnt), 0);
        chk("rst_fail_cnt", 32'(fail_cnt), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_ch", 32'(err_ch), 0);
        rst = 1'b0;
        tick();

        // Mode 1 match, delay 1.
        dly_t = 3'd1;
        chk_m = 4'b0001;
        req   = 4'b0001;
        e     = cyc + 1;
        exp_at(e + 1, 4'b0001, 4'b0000);
        tick();
        req = '0;
        gnt = 4'b0001;
        tick();
        gnt = '0;
        chk("m1_pass_cnt", 32'(pass_cnt), 1);
        chk("m1_fail_cnt", 32'(fail_cnt), 0);
        chk("m1_err", 32'(err), 0);

        // Mode mismatch: grant arrives 2 cycles after req; check=1 wants 1, check=0 wants 2.
        clear();
        chk("clr_pass_cnt", 32'(pass_cnt), 0);
        dly_t = 3'd1;
        dly_f = 3'd2;
        chk_m = 4'b0001;
        req   = 4'b0001;
        e     = cyc + 1;
        exp_at(e + 1, 4'b0000, 4'b0001);
        tick();
        req = '0;
        tick();
        gnt = 4'b0001;
        tick();
        gnt = '0;
        chk("mm_fail_cnt", 32'(fail_cnt), 1);
        chk("mm_err", 32'(err), 1);
        chk("mm_err_ch", 32'(err_ch), 0);
        chk("mm_pass_cnt0", 32'(pass_cnt), 0);
        chk_m = 4'b0000;
        req   = 4'b0001;
        e     = cyc + 1;
        exp_at(e + 2, 4'b0001, 4'b0000);
        tick();
        req = '0;
        tick();
        gnt = 4'b0001;
        tick();
        gnt = '0;
        chk("mm_pass_cnt", 32'(pass_cnt), 1);
        chk("mm_fail_cnt2", 32'(fail_cnt), 1);

        // Collision: d=3 at e and d=2 at e+1 both mature at e+3.
        clear();
        chk("clr_err", 32'(err), 0);
        dly_f = 3'd3;
        dly_t = 3'd2;
        chk_m = 4'b0000;
        req   = 4'b0001;
        e     = cyc + 1;
        exp_at(e + 3, 4'b0001, 4'b0000);
        tick();
        chk_m = 4'b0001;
        tick();
        req = '0;
        tick();
        gnt = 4'b0001;
        tick();
        gnt = '0;
        chk("col_pass_cnt", 32'(pass_cnt), 2);
        chk("col_err", 32'(err), 0);

        // Multi-channel tie: channels 1 and 3 fail together, later channel 0 fails.
        clear();
        dly_f = 3'd1;
        chk_m = 4'b0000;
        req   = 4'b1010;
        e     = cyc + 1;
        exp_at(e + 1, 4'b0000, 4'b1010);
        tick();
        req = '0;
        tick();
        chk("tie_err_ch", 32'(err_ch), 1);
        chk("tie_fail_cnt", 32'(fail_cnt), 2);
        chk("tie_err", 32'(err), 1);
        req = 4'b0001;
        e   = cyc + 1;
        exp_at(e + 1, 4'b0000, 4'b0001);
        tick();
        req = '0;
        tick();
        chk("tie_err_ch_frozen", 32'(err_ch), 1);
        chk("tie_fail_cnt3", 32'(fail_cnt), 3);

        // Saturation: 20 back-to-back passes into a 4-bit counter.
        clear();
        dly_f = 3'd1;
        chk_m = 4'b0000;
        req   = 4'b0001;
        gnt   = 4'b0001;
        e     = cyc + 1;
        for (int i = 0; i < 20; i++) begin
            exp_at(e + 1 + i, 4'b0001, 4'b0000);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 9) chk("sat_mid", 32'(pass_cnt), 9);
        end
        req = '0;
        tick();
        gnt = '0;
        chk("sat_pass_cnt", 32'(pass_cnt), 15);
        chk("sat_fail_cnt", 32'(fail_cnt), 0);

        // Clamping: dly_t=0 acts as 1, dly_t=MAX_DLY+3 acts as MAX_DLY.
        clear();
        dly_t = 3'd0;
        chk_m = 4'b0001;
        req   = 4'b0001;
        e     = cyc + 1;
        exp_at(e + 1, 4'b0001, 4'b0000);
        tick();
        req = '0;
        gnt = 4'b0001;
        tick();
        gnt   = '0;
        dly_t = 3'd7;
        req   = 4'b0001;
        e     = cyc + 1;
        exp_at(e + 4, 4'b0001, 4'b0000);
        tick();
        req = '0;
        tick();
        tick();
        tick();
        gnt = 4'b0001;
        tick();
        gnt = '0;
        chk("clamp_pass_cnt", 32'(pass_cnt), 2);
        chk("clamp_fail_cnt", 32'(fail_cnt), 0);

        // en=0 blocks new starts but a pending attempt still matures.
        clear();
        dly_t = 3'd2;
        chk_m = 4'b0001;
        req   = 4'b0001;
        e     = cyc + 1;
        exp_at(e + 2, 4'b0001, 4'b0000);
        tick();
        en = 1'b0;
        tick();
        req = '0;
        gnt = 4'b0001;
        tick();
        tick();
        gnt = '0;
        en  = 1'b1;
        chk("en_pass_cnt", 32'(pass_cnt), 1);
        chk("en_fail_cnt", 32'(fail_cnt), 0);

        // Clear mid-flight, with req held during the clear edge.
        clear();
        dly_t = 3'd4;
        chk_m = 4'b0001;
        req   = 4'b0001;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        req = '0;
        for (int i = 0; i < 8; i++) tick();
        chk("clrmf_pass_cnt", 32'(pass_cnt), 0);
        chk("clrmf_fail_cnt", 32'(fail_cnt), 0);
        chk("clrmf_err", 32'(err), 0);

        // Reset mid-flight: discards ch2 attempts and the earlier pass count.
        dly_f = 3'd1;
        dly_t = 3'd4;
        chk_m = 4'b0100;
        req   = 4'b0110;
        e     = cyc + 1;
        exp_at(e + 1, 4'b0010, 4'b0000);
        tick();
        req = 4'b0100;
        gnt = 4'b0010;
        tick();
        req = '0;
        gnt = '0;
        chk("rstmf_pass_pre", 32'(pass_cnt), 1);
        #1 rst = 1'b1;
        #1 chk("rstmf_async", 32'(pass_cnt), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("rstmf_pass_cnt", 32'(pass_cnt), 0);
        chk("rstmf_fail_cnt", 32'(fail_cnt), 0);
        chk("rstmf_err", 32'(err), 0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
